// File: rtl/kl_mbox_pkg.sv
// Shared types for the MBOX request arbiter: sequencer states, request owner
// and VMA width.
package kl_mbox_pkg;

    localparam int unsigned VMA_W = 23;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StBackoff,
        StDone
    } state_e;

    typedef enum logic {
        OWN_EBOX,
        OWN_SWEEP
    } owner_e;

endpackage

// File: rtl/mbox_arb_timer.sv
// Loadable down-counter that saturates at zero; zero_o flags an expired count.
module mbox_arb_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mbox_req_arb.sv
// Arbitrates EBOX and cache-sweeper requests onto the MBOX request port and
// sequences each request through issue, response wait, retry backoff and timeout.
module mbox_req_arb
    import kl_mbox_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned BACKOFF   = 4,
    parameter int unsigned FAIR      = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  ebReq,
    input  logic                  ebWrite,
    input  logic [13:13+VMA_W-1]  ebVMA,
    input  logic                  swReq,
    input  logic [13:13+VMA_W-1]  swAdr,
    output logic                  ebDone,
    output logic                  swDone,
    output logic                  reqErr,
    output logic                  timeoutErr,
    output logic                  mboxReq,
    output logic [13:13+VMA_W-1]  mboxAdr,
    output logic                  mboxWrite,
    output logic                  mboxSweep,
    input  logic                  mboxAck,
    input  logic                  mboxRetry,
    input  logic                  mboxResp,
    output logic                  busy
);

    localparam int unsigned TmW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned BoW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
    localparam int unsigned RcW = $clog2(MAX_RETRY + 2);
    localparam int unsigned SkW = (FAIR > 0) ? $clog2(FAIR + 1) : 1;

    state_e               state_q, state_d;
    owner_e               owner_q, owner_d;
    logic [13:13+VMA_W-1] adr_q, adr_d;
    logic                 write_q, write_d;
    logic [RcW-1:0]       retry_q, retry_d;
    logic [SkW-1:0]       streak_q, streak_d;
    logic                 eb_done_q, sw_done_q, req_err_q, tmo_err_q, mbox_req_q, busy_q;

    logic tmo_load, tmo_zero, bo_load, bo_zero;
    logic do_retry, fin_err, fin_tmo, sw_win;

    // Timeout counter runs only while a request is live on the port (ISSUE/WAIT).
    mbox_arb_timer #(
        .Width (TmW)
    ) u_tmo_timer (
        .clk_i      (clk),
        .rst_ni     (resetN),
        .load_i     (tmo_load),
        .load_val_i (TmW'(TIMEOUT - 1)),
        .dec_i      ((state_q == StIssue) || (state_q == StWait)),
        .zero_o     (tmo_zero)
    );

    mbox_arb_timer #(
        .Width (BoW)
    ) u_bo_timer (
        .clk_i      (clk),
        .rst_ni     (resetN),
        .load_i     (bo_load),
        .load_val_i (BoW'(BACKOFF - 1)),
        .dec_i      (state_q == StBackoff),
        .zero_o     (bo_zero)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        adr_d    = adr_q;
        write_d  = write_q;
        retry_d  = retry_q;
        streak_d = streak_q;
        tmo_load = 1'b0;
        bo_load  = 1'b0;
        do_retry = 1'b0;
        fin_err  = 1'b0;
        fin_tmo  = 1'b0;
        sw_win   = swReq && (!ebReq || (32'(streak_q) == FAIR));

        unique case (state_q)
            StIdle: begin
                if (ebReq || swReq) begin
                    if (sw_win) begin
                        owner_d  = OWN_SWEEP;
                        adr_d    = swAdr;
                        write_d  = 1'b0;
                        streak_d = '0;
                    end else begin
                        owner_d  = OWN_EBOX;
                        adr_d    = ebVMA;
                        write_d  = ebWrite;
                        if (!swReq) begin
                            streak_d = '0;
                        end else if (32'(streak_q) != FAIR) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end
                    retry_d  = '0;
                    tmo_load = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (mboxRetry) begin
                    do_retry = 1'b1;
                end else if (mboxAck) begin
                    state_d = StWait;
                end else if (tmo_zero) begin
                    state_d = StDone;
                    fin_err = 1'b1;
                    fin_tmo = 1'b1;
                end
            end
            StWait: begin
                if (mboxResp) begin
                    state_d = StDone;
                end else if (mboxRetry) begin
                    do_retry = 1'b1;
                end else if (tmo_zero) begin
                    state_d = StDone;
                    fin_err = 1'b1;
                    fin_tmo = 1'b1;
                end
            end
            StBackoff: begin
                if (bo_zero) begin
                    state_d = StIssue;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_retry) begin
            retry_d = retry_q + 1'b1;
            if (32'(retry_q) >= MAX_RETRY) begin
                state_d = StDone;
                fin_err = 1'b1;
            end else begin
                bo_load = 1'b1;
                state_d = StBackoff;
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= StIdle;
            owner_q    <= OWN_EBOX;
            adr_q      <= '0;
            write_q    <= 1'b0;
            retry_q    <= '0;
            streak_q   <= '0;
            eb_done_q  <= 1'b0;
            sw_done_q  <= 1'b0;
            req_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
            mbox_req_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            adr_q      <= adr_d;
            write_q    <= write_d;
            retry_q    <= retry_d;
            streak_q   <= streak_d;
            eb_done_q  <= (state_d == StDone) && (owner_d == OWN_EBOX);
            sw_done_q  <= (state_d == StDone) && (owner_d == OWN_SWEEP);
            req_err_q  <= (state_d == StDone) && fin_err;
            tmo_err_q  <= (state_d == StDone) && fin_tmo;
            mbox_req_q <= (state_d == StIssue);
            busy_q     <= (state_d != StIdle);
        end
    end

    assign ebDone     = eb_done_q;
    assign swDone     = sw_done_q;
    assign reqErr     = req_err_q;
    assign timeoutErr = tmo_err_q;
    assign mboxReq    = mbox_req_q;
    assign mboxAdr    = adr_q;
    assign mboxWrite  = write_q;
    assign mboxSweep  = (owner_q == OWN_SWEEP);
    assign busy       = busy_q;

endmodule

// File: tb/tb_mbox_req_arb.sv
// Directed bench for mbox_req_arb: a scoreboard queue holds the expected grant
// and completion of each request and is checked when the DUT grants and finishes.
module tb_mbox_req_arb;

    logic          clk;
    logic          resetN;
    logic          ebReq, ebWrite, swReq;
    logic [13:35]  ebVMA, swAdr, mboxAdr;
    logic          ebDone, swDone, reqErr, timeoutErr;
    logic          mboxReq, mboxWrite, mboxSweep, busy;
    logic          mboxAck, mboxRetry, mboxResp;

    typedef struct packed {
        logic        sweep;
        logic [22:0] adr;
        logic        wr;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    mbox_req_arb #(
        .TIMEOUT   (64),
        .MAX_RETRY (3),
        .BACKOFF   (4),
        .FAIR      (4)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .ebReq      (ebReq),
        .ebWrite    (ebWrite),
        .ebVMA      (ebVMA),
        .swReq      (swReq),
        .swAdr      (swAdr),
        .ebDone     (ebDone),
        .swDone     (swDone),
        .reqErr     (reqErr),
        .timeoutErr (timeoutErr),
        .mboxReq    (mboxReq),
        .mboxAdr    (mboxAdr),
        .mboxWrite  (mboxWrite),
        .mboxSweep  (mboxSweep),
        .mboxAck    (mboxAck),
        .mboxRetry  (mboxRetry),
        .mboxResp   (mboxResp),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push(input logic sweep, input logic [22:0] adr, input logic wr,
                        input logic err, input logic tmo);
        exp_t e;
        e.sweep = sweep;
        e.adr   = adr;
        e.wr    = wr;
        e.err   = err;
        e.tmo   = tmo;
        sbq.push_back(e);
    endtask

    // Waits for mboxReq and checks the latched request against the queue head.
    task automatic grant_check(input int budget, output int waited);
        exp_t e;
        waited = 0;
        while (!mboxReq && waited < budget) begin
            tick();
            waited++;
        end
        e = (sbq.size() > 0) ? sbq[0] : '0;
        chkb("grant_mboxReq", mboxReq, 1'b1);
        chkb("grant_mboxSweep", mboxSweep, e.sweep);
        chk("grant_mboxAdr", 32'(mboxAdr), 32'(e.adr));
        chkb("grant_mboxWrite", mboxWrite, e.wr);
        chkb("grant_busy", busy, 1'b1);
    endtask

    // Waits for a done pulse, checks it against the popped expectation, then
    // (unless hold) drops the owner's request and checks the pulse lasts one cycle.
    task automatic done_check(input int budget, input bit hold, output int waited);
        exp_t e;
        waited = 0;
        while (!(ebDone || swDone) && waited < budget) begin
            tick();
            waited++;
        end
        e = (sbq.size() > 0) ? sbq.pop_front() : '0;
        chkb("done_ebDone", ebDone, !e.sweep);
        chkb("done_swDone", swDone, e.sweep);
        chkb("done_reqErr", reqErr, e.err);
        chkb("done_timeoutErr", timeoutErr, e.tmo);
        if (!hold) begin
            if (e.sweep) swReq = 1'b0;
            else ebReq = 1'b0;
        end
        tick();
        chkb("done_one_cycle", ebDone | swDone, 1'b0);
    endtask

    task automatic gap_check(input string tag, input int exp_gap);
        int n;
        n = 0;
        while (!mboxReq && n < 20) begin
            chkb({tag, "_busy"}, busy, 1'b1);
            tick();
            n++;
        end
        chk(tag, n, exp_gap);
    endtask

    initial begin
        int w;
        logic [9:0] pat;

        resetN = 1'b0;  ebReq = 1'b0; ebWrite = 1'b0; swReq = 1'b0;
        ebVMA = '0;     swAdr = '0;   mboxAck = 1'b0; mboxRetry = 1'b0; mboxResp = 1'b0;
        #12;
        chkb("rst_mboxReq", mboxReq, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_ebDone", ebDone, 1'b0);
        chkb("rst_swDone", swDone, 1'b0);
        chkb("rst_reqErr", reqErr, 1'b0);
        chkb("rst_timeoutErr", timeoutErr, 1'b0);
        chk("rst_mboxAdr", 32'(mboxAdr), 0);
        chkb("rst_mboxWrite", mboxWrite, 1'b0);
        chkb("rst_mboxSweep", mboxSweep, 1'b0);
        tick();
        resetN = 1'b1;
        tick();

        // Minimum EBOX write: grant at 1, ack 1, resp 2, done 3.
        ebReq = 1'b1; ebWrite = 1'b1; ebVMA = 23'h012345;
        push(1'b0, 23'h012345, 1'b1, 1'b0, 1'b0);
        grant_check(5, w);
        chk("min_grant_lat", w, 1);
        mboxAck = 1'b1;
        tick();
        mboxAck = 1'b0;
        chkb("min_req_drop", mboxReq, 1'b0);
        mboxResp = 1'b1;
        tick();
        mboxResp = 1'b0;
        done_check(0, 1'b0, w);
        chk("min_done_lat", w, 0);
        chkb("min_idle_busy", busy, 1'b0);

        // Both requesters held: four EBOX grants per sweeper grant.
        swAdr = 23'h7abcde;
        ebReq = 1'b1; swReq = 1'b1;
        pat = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            if (pat[i]) push(1'b1, 23'h7abcde, 1'b0, 1'b0, 1'b0);
            else push(1'b0, 23'h012345, 1'b1, 1'b0, 1'b0);
            grant_check(6, w);
            mboxAck = 1'b1;
            tick();
            mboxAck = 1'b0;
            mboxResp = 1'b1;
            tick();
            mboxResp = 1'b0;
            done_check(0, 1'b1, w);
        end
        ebReq = 1'b0; swReq = 1'b0;
        tick();

        // Two retries (second with simultaneous ack), then success.
        ebReq = 1'b1; ebWrite = 1'b0; ebVMA = 23'h000abc;
        push(1'b0, 23'h000abc, 1'b0, 1'b0, 1'b0);
        grant_check(5, w);
        mboxRetry = 1'b1;
        tick();
        mboxRetry = 1'b0;
        gap_check("retry1_gap", 4);
        chk("retry1_adr_hold", 32'(mboxAdr), 32'h000abc);
        mboxRetry = 1'b1; mboxAck = 1'b1;
        tick();
        mboxRetry = 1'b0; mboxAck = 1'b0;
        chkb("ackretry_req_drop", mboxReq, 1'b0);
        gap_check("retry2_gap", 4);
        mboxAck = 1'b1;
        tick();
        mboxAck = 1'b0;
        mboxResp = 1'b1;
        tick();
        mboxResp = 1'b0;
        done_check(0, 1'b0, w);

        // Four retries (third one in WAIT): aborts on the fourth.
        ebReq = 1'b1; ebVMA = 23'h055555;
        push(1'b0, 23'h055555, 1'b0, 1'b1, 1'b0);
        grant_check(5, w);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                mboxAck = 1'b1;
                tick();
                mboxAck = 1'b0;
            end
            mboxRetry = 1'b1;
            tick();
            mboxRetry = 1'b0;
            if (k < 3) gap_check("retryN_gap", 4);
        end
        done_check(0, 1'b0, w);
        chk("retry_abort_lat", w, 0);

        // No ack at all: timeout 64 cycles after the grant.
        ebReq = 1'b1; ebVMA = 23'h011111;
        push(1'b0, 23'h011111, 1'b0, 1'b1, 1'b1);
        grant_check(5, w);
        done_check(100, 1'b0, w);
        chk("timeout_lat", w, 64);

        // Response in the timer's final cycle wins over the timeout.
        ebReq = 1'b1; ebVMA = 23'h022222;
        push(1'b0, 23'h022222, 1'b0, 1'b0, 1'b0);
        grant_check(5, w);
        mboxAck = 1'b1;
        tick();
        mboxAck = 1'b0;
        repeat (62) tick();
        chkb("late_resp_busy", busy, 1'b1);
        mboxResp = 1'b1;
        tick();
        mboxResp = 1'b0;
        done_check(0, 1'b0, w);
        chk("late_resp_lat", w, 0);

        // Reset during WAIT abandons the request; held ebReq is re-granted.
        ebReq = 1'b1; ebVMA = 23'h033333;
        push(1'b0, 23'h033333, 1'b0, 1'b0, 1'b0);
        grant_check(5, w);
        mboxAck = 1'b1;
        tick();
        mboxAck = 1'b0;
        chkb("wait_busy", busy, 1'b1);
        #2;
        resetN = 1'b0;
        #1;
        chkb("midrst_mboxReq", mboxReq, 1'b0);
        chkb("midrst_busy", busy, 1'b0);
        chkb("midrst_ebDone", ebDone, 1'b0);
        chk("midrst_mboxAdr", 32'(mboxAdr), 0);
        void'(sbq.pop_front());
        tick();
        resetN = 1'b1;
        push(1'b0, 23'h033333, 1'b0, 1'b0, 1'b0);
        grant_check(5, w);
        chk("rerst_grant_lat", w, 1);
        mboxAck = 1'b1;
        tick();
        mboxAck = 1'b0;
        mboxResp = 1'b1;
        tick();
        mboxResp = 1'b0;
        done_check(0, 1'b0, w);

        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
